// File: rtl/dbg_bridge_cmd.sv
// UART debug bridge: decodes CMD/LEN/ADDR[/DATA] frames from a UART byte stream
// into byte-wide bus writes (acked with 0x06) or reads (data echoed back).
module dbg_bridge_cmd #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_ready_i,
    input  logic [7:0]  uart_data_i,
    input  logic        uart_rx_err_i,
    output logic        uart_rd_o,
    input  logic        uart_tx_busy_i,
    output logic        uart_wr_o,
    output logic [7:0]  uart_data_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_wr_o,
    output logic        mem_rd_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        busy_o
);

    localparam logic [7:0] CMD_WR   = 8'h10;
    localparam logic [7:0] CMD_RD   = 8'h11;
    localparam logic [7:0] ACK_BYTE = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN, ST_ADDR, ST_WDATA, ST_BUS_WR, ST_BUS_RD, ST_TX_DATA, ST_TX_ACK
    } state_t;

    state_t               state, state_next;
    logic                 is_wr;
    logic [7:0]           count;
    logic [31:0]          addr;
    logic [7:0]           wdata;
    logic [7:0]           rdata;
    logic [1:0]           addr_idx;
    logic [TIMEOUT_W-1:0] timeout;
    logic                 rd_q;
    logic                 wr_q;
    logic                 accepted;

    logic rx_state, frame_state, pop, err_pop, tmo, bus_done, tx_fire;

    // rd_q/wr_q keep pops and transmit strobes at least one idle cycle apart
    always_comb begin
        rx_state    = (state == ST_IDLE) || (state == ST_LEN) ||
                      (state == ST_ADDR) || (state == ST_WDATA);
        frame_state = (state == ST_LEN) || (state == ST_ADDR) || (state == ST_WDATA);
        pop         = rx_state && !rd_q && (uart_rx_ready_i || (frame_state && uart_rx_err_i));
        err_pop     = pop && frame_state && uart_rx_err_i;
        tmo         = frame_state && !pop && (timeout == '1);
        bus_done    = mem_ack_i && (accepted || mem_accept_i);
        tx_fire     = ((state == ST_TX_DATA) || (state == ST_TX_ACK)) && !uart_tx_busy_i && !wr_q;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pop && !uart_rx_err_i && ((uart_data_i == CMD_WR) || (uart_data_i == CMD_RD)))
                    state_next = ST_LEN;
            end
            ST_LEN: begin
                if (err_pop || tmo)
                    state_next = ST_IDLE;
                else if (pop)
                    state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (err_pop || tmo)
                    state_next = ST_IDLE;
                else if (pop && (addr_idx == 2'd3)) begin
                    if (count == 8'd0)
                        state_next = is_wr ? ST_TX_ACK : ST_IDLE;
                    else
                        state_next = is_wr ? ST_WDATA : ST_BUS_RD;
                end
            end
            ST_WDATA: begin
                if (err_pop || tmo)
                    state_next = ST_IDLE;
                else if (pop)
                    state_next = ST_BUS_WR;
            end
            ST_BUS_WR: begin
                if (bus_done)
                    state_next = (count == 8'd1) ? ST_TX_ACK : ST_WDATA;
            end
            ST_BUS_RD: begin
                if (bus_done)
                    state_next = ST_TX_DATA;
            end
            ST_TX_DATA: begin
                if (tx_fire)
                    state_next = (count == 8'd0) ? ST_IDLE : ST_BUS_RD;
            end
            ST_TX_ACK: begin
                if (tx_fire)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Frame datapath: address/count advance only once a bus access has been acked
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_wr    <= 1'b0;
            count    <= 8'd0;
            addr     <= 32'd0;
            wdata    <= 8'd0;
            rdata    <= 8'd0;
            addr_idx <= 2'd0;
            timeout  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            accepted <= 1'b0;
        end else begin
            rd_q <= pop;
            wr_q <= tx_fire;

            if (!frame_state || pop)
                timeout <= '0;
            else if (timeout != '1)
                timeout <= timeout + TIMEOUT_W'(1);

            case (state)
                ST_IDLE: begin
                    if (pop)
                        is_wr <= (uart_data_i == CMD_WR);
                end
                ST_LEN: begin
                    if (pop && !err_pop) begin
                        count    <= uart_data_i;
                        addr     <= 32'd0;
                        addr_idx <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (pop && !err_pop) begin
                        addr     <= {addr[23:0], uart_data_i};
                        addr_idx <= addr_idx + 2'd1;
                    end
                end
                ST_WDATA: begin
                    if (pop && !err_pop)
                        wdata <= uart_data_i;
                end
                ST_BUS_WR, ST_BUS_RD: begin
                    if (bus_done) begin
                        accepted <= 1'b0;
                        addr     <= addr + 32'd1;
                        count    <= count - 8'd1;
                        if (state == ST_BUS_RD)
                            rdata <= mem_rdata_i;
                    end else if (mem_accept_i) begin
                        accepted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uart_rd_o   = pop;
    assign uart_wr_o   = tx_fire;
    assign uart_data_o = (state == ST_TX_ACK) ? ACK_BYTE : rdata;
    assign mem_addr_o  = addr;
    assign mem_wdata_o = wdata;
    assign mem_wr_o    = (state == ST_BUS_WR) && !accepted;
    assign mem_rd_o    = (state == ST_BUS_RD) && !accepted;
    assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_dbg_bridge_cmd.sv
// Scoreboard bench for dbg_bridge_cmd: directed frames feed a UART RX model, and
// bus/UART TX monitors pop expected events from queues and compare.
module tb_dbg_bridge_cmd;

    localparam int TW = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx_ready_i, uart_rx_err_i, uart_rd_o;
    logic [7:0]  uart_data_i;
    logic        uart_tx_busy_i, uart_wr_o;
    logic [7:0]  uart_data_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o, mem_rdata_i;
    logic        mem_wr_o, mem_rd_o, mem_accept_i, mem_ack_i, busy_o;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [7:0]  data;
    } bus_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } rx_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rd_data_q[$];
    rx_t        rx_q[$];

    int   total = 0;
    int   bad = 0;
    int   accept_delay = 0;
    int   ack_lag = 0;
    logic force_busy = 1'b0;

    dbg_bridge_cmd #(.TIMEOUT_W(TW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .uart_rx_ready_i(uart_rx_ready_i),
        .uart_data_i    (uart_data_i),
        .uart_rx_err_i  (uart_rx_err_i),
        .uart_rd_o      (uart_rd_o),
        .uart_tx_busy_i (uart_tx_busy_i),
        .uart_wr_o      (uart_wr_o),
        .uart_data_o    (uart_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_wr_o       (mem_wr_o),
        .mem_rd_o       (mem_rd_o),
        .mem_accept_i   (mem_accept_i),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART receiver model: outputs change at negedge, pops are sampled just after
    initial begin
        bit rd_pend;
        bit rd_prev;
        rd_pend = 0;
        rd_prev = 0;
        uart_rx_ready_i = 1'b0;
        uart_data_i = 8'h00;
        uart_rx_err_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_pend && rst_n && rx_q.size() > 0)
                rx_q.delete(0);
            rd_pend = 0;
            if (rx_q.size() > 0) begin
                uart_rx_ready_i = 1'b1;
                uart_data_i = rx_q[0].data;
                uart_rx_err_i = rx_q[0].err;
            end else begin
                uart_rx_ready_i = 1'b0;
                uart_data_i = 8'h00;
                uart_rx_err_i = 1'b0;
            end
            #1;
            if (uart_rd_o) begin
                check_output("rd_gap", 32'(rd_prev), 32'd0);
                rd_pend = 1;
            end
            rd_prev = uart_rd_o;
        end
    end

    // UART transmitter model: busy rises one cycle after a strobe, as a real UART does
    initial begin
        int         busy_cnt;
        bit         tx_lag;
        bit         wr_prev;
        logic [7:0] e;
        busy_cnt = 0;
        tx_lag = 0;
        wr_prev = 0;
        uart_tx_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                tx_lag = 0;
            end
            if (tx_lag) begin
                tx_lag = 0;
                uart_tx_busy_i = force_busy;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                uart_tx_busy_i = 1'b1;
            end else begin
                uart_tx_busy_i = force_busy;
            end
            #1;
            if (uart_wr_o) begin
                check_output("wr_gap", 32'(wr_prev), 32'd0);
                check_output("wr_busy", 32'(uart_tx_busy_i), 32'd0);
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL tx_unexpected: got 0x%0h expected no byte at %0t", uart_data_o, $time);
                end else begin
                    e = exp_tx.pop_front();
                    check_output("tx_byte", 32'(uart_data_o), 32'(e));
                end
                tx_lag = 1;
                busy_cnt = 3;
            end
            wr_prev = uart_wr_o;
        end
    end

    // Bus responder and monitor: stalls accept, optionally delays ack, checks each access
    initial begin
        int         wait_cnt;
        int         lag_cnt;
        bit         pending;
        logic [7:0] pend_rdata;
        logic [7:0] rd_val;
        bus_t       cap;
        bus_t       e;
        wait_cnt = 0;
        lag_cnt = 0;
        pending = 0;
        pend_rdata = 8'h00;
        mem_accept_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_rdata_i = 8'h00;
        forever begin
            @(negedge clk);
            mem_accept_i = 1'b0;
            mem_ack_i = 1'b0;
            if (!rst_n) begin
                pending = 0;
                wait_cnt = 0;
            end else if (pending) begin
                check_output("bus_quiet", 32'(mem_wr_o | mem_rd_o), 32'd0);
                if (lag_cnt >= ack_lag) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = pend_rdata;
                    pending = 0;
                end else begin
                    lag_cnt++;
                end
            end else if (mem_wr_o || mem_rd_o) begin
                check_output("bus_excl", 32'(mem_wr_o & mem_rd_o), 32'd0);
                if (wait_cnt == 0) begin
                    cap.is_wr = mem_wr_o;
                    cap.addr = mem_addr_o;
                    cap.data = mem_wdata_o;
                end else begin
                    check_output("stall_kind", 32'(mem_wr_o), 32'(cap.is_wr));
                    check_output("stall_addr", mem_addr_o, cap.addr);
                    check_output("stall_data", 32'(mem_wdata_o), 32'(cap.data));
                end
                if (wait_cnt < accept_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    mem_accept_i = 1'b1;
                    rd_val = 8'h00;
                    if (mem_rd_o && rd_data_q.size() > 0)
                        rd_val = rd_data_q.pop_front();
                    if (exp_bus.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL bus_unexpected: got wr=%0b addr=0x%0h expected no access at %0t",
                                 mem_wr_o, mem_addr_o, $time);
                    end else begin
                        e = exp_bus.pop_front();
                        check_output("bus_kind", 32'(mem_wr_o), 32'(e.is_wr));
                        check_output("bus_addr", mem_addr_o, e.addr);
                        if (e.is_wr)
                            check_output("bus_wdata", 32'(mem_wdata_o), 32'(e.data));
                    end
                    if (ack_lag == 0) begin
                        mem_ack_i = 1'b1;
                        mem_rdata_i = rd_val;
                    end else begin
                        pending = 1;
                        lag_cnt = 1;
                        pend_rdata = rd_val;
                    end
                end
            end
        end
    end

    // Bytes are packed right-aligned, first byte of the frame most significant
    task automatic apply_stimulus(input logic [63:0] bytes, input int n);
        rx_t r;
        for (int i = 0; i < n; i++) begin
            r.data = bytes[8*(n-1-i) +: 8];
            r.err = 1'b0;
            rx_q.push_back(r);
        end
    endtask

    task automatic push_err_byte(input logic [7:0] b);
        rx_t r;
        r.data = b;
        r.err = 1'b1;
        rx_q.push_back(r);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
        bus_t b;
        b.is_wr = 1'b1;
        b.addr = a;
        b.data = d;
        exp_bus.push_back(b);
    endtask

    task automatic expect_rd(input logic [31:0] a, input logic [7:0] d);
        bus_t b;
        b.is_wr = 1'b0;
        b.addr = a;
        b.data = 8'h00;
        exp_bus.push_back(b);
        rd_data_q.push_back(d);
        exp_tx.push_back(d);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int stable;
        int n;
        stable = 0;
        n = 0;
        while (stable < 4 && n < budget) begin
            @(negedge clk);
            #3;
            n++;
            if (rx_q.size() == 0 && !busy_o && exp_bus.size() == 0 && exp_tx.size() == 0)
                stable++;
            else
                stable = 0;
        end
        check_output({name, "_idle"}, 32'(stable >= 4), 32'd1);
        check_output({name, "_bus_left"}, 32'(exp_bus.size()), 32'd0);
        check_output({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
        exp_bus.delete();
        exp_tx.delete();
        rd_data_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_rd"}, 32'(uart_rd_o), 32'd0);
        check_output({name, "_wr"}, 32'(uart_wr_o), 32'd0);
        check_output({name, "_mem_wr"}, 32'(mem_wr_o), 32'd0);
        check_output({name, "_mem_rd"}, 32'(mem_rd_o), 32'd0);
        check_output({name, "_busy"}, 32'(busy_o), 32'd0);
        check_output({name, "_addr"}, mem_addr_o, 32'd0);
        check_output({name, "_wdata"}, 32'(mem_wdata_o), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        check_output("reset_txdata", 32'(uart_data_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // two-byte write, ack in the accept cycle
        expect_wr(32'h0000_1000, 8'hAA);
        expect_wr(32'h0000_1001, 8'hBB);
        exp_tx.push_back(8'h06);
        apply_stimulus(64'h10_02_00_00_10_00_AA_BB, 8);
        wait_idle("write2", 400);

        // three-byte read wrapping past 0xFFFFFFFF, ack two cycles after accept
        ack_lag = 2;
        expect_rd(32'hFFFF_FFFE, 8'h01);
        expect_rd(32'hFFFF_FFFF, 8'h02);
        expect_rd(32'h0000_0000, 8'h03);
        apply_stimulus(64'h11_03_FF_FF_FF_FE, 6);
        wait_idle("read_wrap", 400);
        ack_lag = 0;

        // accept withheld for five cycles
        accept_delay = 5;
        expect_wr(32'h0000_0400, 8'h5C);
        exp_tx.push_back(8'h06);
        apply_stimulus(64'h10_01_00_00_04_00_5C, 7);
        wait_idle("stall", 400);
        accept_delay = 0;

        // unknown command byte is dropped in IDLE
        apply_stimulus(64'h55, 1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            check_output("junk_busy", 32'(busy_o), 32'd0);
            check_output("junk_bus", 32'(mem_wr_o | mem_rd_o), 32'd0);
        end
        wait_idle("junk", 50);

        // frame stalls mid-address and must time out
        apply_stimulus(64'h10_02_00_00, 4);
        repeat (30) @(negedge clk);
        #3;
        check_output("tmo_hold", 32'(busy_o), 32'd1);
        wait_idle("tmo", 300);
        expect_wr(32'h1234_5678, 8'h9D);
        exp_tx.push_back(8'h06);
        apply_stimulus(64'h10_01_12_34_56_78_9D, 7);
        wait_idle("after_tmo", 400);

        // framing error on the second data byte keeps the first write only
        expect_wr(32'h0000_2000, 8'hAA);
        apply_stimulus(64'h10_02_00_00_20_00_AA, 7);
        push_err_byte(8'hBB);
        wait_idle("frame_err", 400);

        // zero-length write answers with the ack byte only
        exp_tx.push_back(8'h06);
        apply_stimulus(64'h10_00_00_00_00_40, 6);
        wait_idle("len0", 300);

        // transmitter busy holds off the read data
        force_busy = 1'b1;
        expect_rd(32'h0000_5000, 8'hC3);
        expect_rd(32'h0000_5001, 8'h3C);
        apply_stimulus(64'h11_02_00_00_50_00, 6);
        n = 0;
        while (exp_bus.size() != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("txbusy_reach", 32'(exp_bus.size()), 32'd1);
        repeat (10) @(negedge clk);
        #3;
        check_output("txbusy_withheld", 32'(exp_tx.size()), 32'd2);
        force_busy = 1'b0;
        wait_idle("txbusy", 400);

        // reset while a write is stalled on the bus drops the frame
        accept_delay = 50;
        apply_stimulus(64'h10_01_00_00_60_00_77, 7);
        n = 0;
        while (!mem_wr_o && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check_output("rst_reach_bus", 32'(mem_wr_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rx_q.delete();
        accept_delay = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        expect_rd(32'h0000_0007, 8'hE1);
        apply_stimulus(64'h11_01_00_00_00_07, 6);
        wait_idle("post_rst", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("[TB] FAIL watchdog: got no completion expected finish before %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dbg_bridge_cmd.md
DBG_BRIDGE_CMD -- requirements
Module: dbg_bridge_cmd

Interface
REQ-001 Parameter: TIMEOUT_W, default 16, width of the inter-byte timeout counter.
REQ-002 clk_i  input  1  clock; all state on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 uart_rx_ready_i  input  1  byte available from UART receiver.
REQ-005 uart_data_i  input  8  received byte.
REQ-006 uart_rx_err_i  input  1  UART framing error flag.
REQ-007 uart_rd_o  output  1  one-cycle pop of received byte; also clears the error flag.
REQ-008 uart_tx_busy_i  input  1  UART transmitter busy.
REQ-009 uart_wr_o  output  1  one-cycle transmit strobe.
REQ-010 uart_data_o  output  8  byte to transmit.
REQ-011 mem_addr_o  output  32  bus byte address.
REQ-012 mem_wdata_o  output  8  bus write data.
REQ-013 mem_wr_o / mem_rd_o  output  1 each  bus write/read request; mutually exclusive.
REQ-014 mem_accept_i  input  1  request accepted this cycle.
REQ-015 mem_ack_i  input  1  request completed; mem_rdata_i valid.
REQ-016 mem_rdata_i  input  8  bus read data.
REQ-017 busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 Frame format SHALL be: CMD, LEN, ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], then LEN data bytes for writes only.
REQ-019 CMD 0x10 SHALL be write; CMD 0x11 SHALL be read; any other CMD SHALL be popped and discarded, with the FSM remaining in IDLE.
REQ-020 LEN SHALL be 0..255; LEN=0 SHALL perform no bus access, and the FSM SHALL go straight to the response state.
REQ-021 FSM states SHALL be: IDLE, LEN, ADDR, WDATA, BUS_WR, BUS_RD, TX_DATA, TX_ACK.
REQ-022 Byte pop: uart_rd_o SHALL assert for exactly one cycle when uart_rx_ready_i=1 in IDLE/LEN/ADDR/WDATA, with uart_data_i captured in that same cycle.
REQ-023 uart_rd_o SHALL NOT assert in two consecutive cycles.
REQ-024 Write: each data byte SHALL be captured into mem_wdata_o, then mem_wr_o SHALL be held with stable address/data until mem_accept_i=1.
REQ-025 After acceptance, the block SHALL wait for mem_ack_i (which may coincide with the accept cycle), then increment the address by 1 with 32-bit wrap, decrement the remaining count, and return to WDATA or, when the count reaches 0, go to TX_ACK.
REQ-026 Read: mem_rd_o SHALL be held until mem_accept_i=1, and mem_rdata_i SHALL be latched on mem_ack_i.
REQ-027 After each read, the FSM SHALL enter TX_DATA, then issue the next read or go to IDLE after the last byte; reads SHALL return no trailing ack.
REQ-028 Transmit: uart_wr_o SHALL pulse for one cycle only when uart_tx_busy_i=0, and SHALL NOT assert in two consecutive cycles (the busy flag lags by one cycle).
REQ-029 TX_ACK SHALL send byte 0x06 once, then return to IDLE.
REQ-030 Addresses SHALL be assembled MSB first, with the address register shifting left by 8 per ADDR byte (4 bytes).
REQ-031 Timeout: in LEN/ADDR/WDATA, if the timeout counter saturates at all-ones with no byte popped, the FSM SHALL return to IDLE without a response; every pop SHALL reset the counter.
REQ-032 Framing error: uart_rx_err_i=1 while in LEN/ADDR/WDATA SHALL pop (uart_rd_o pulse), then abort to IDLE with no bus access and no response; partial writes already completed SHALL stand.
REQ-033 An error or timeout SHALL NOT abort BUS_WR/BUS_RD mid-request: the outstanding request SHALL complete (accept and ack), then the FSM SHALL proceed normally.
REQ-034 uart_rx_ready_i SHALL be ignored in BUS_*/TX_* states, and bytes SHALL remain buffered in the UART.

Reset
REQ-035 On rst_i=0, the block SHALL immediately enter IDLE, with uart_rd_o=0, uart_wr_o=0, mem_wr_o=0, mem_rd_o=0, busy_o=0, and all address/data/count/timeout registers at 0.
REQ-036 Reset mid-frame or mid-bus-request SHALL drop the frame, and the bench SHALL not expect any completion.

Verification
REQ-037 Write 10 02 00 00 10 00 AA BB -> bus writes 0x1000=0xAA, 0x1001=0xBB; UART transmits 0x06.
REQ-038 Read 11 03 FF FF FF FE with mem returning 01,02,03 -> reads at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap); UART transmits 01 02 03; no 0x06.
REQ-039 mem_accept_i held low 5 cycles -> mem_wr_o, mem_addr_o and mem_wdata_o stable all 5 cycles; single write issued.
REQ-040 Byte 0x55 in IDLE -> popped, no bus activity, busy_o stays 0.
REQ-041 Write frame stalls after 2 address bytes for 2^TIMEOUT_W cycles -> return to IDLE; next valid frame executes correctly.
REQ-042 uart_tx_busy_i held high during TX_DATA -> uart_wr_o withheld until busy falls, then exactly one pulse per byte.
